ether_rx_ctrl: RTL

ETHER_RX_CTRL -- requirements
Module: ether_rx_ctrl

---
 rtl/ether_rx_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ether_rx_ctrl.sv
// RMII receive controller: assembles dibits into bytes, filters on destination
// address, forwards payload bytes and reports a per-frame verdict with counters.
module ether_rx_ctrl #(
  parameter logic [47:0] MAC_ADDR = 48'h69_69_5A_06_54_91,
  parameter int          MIN_LEN  = 64,
  parameter int          MAX_LEN  = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [7:0]  axiod,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [10:0] frame_len,
  output logic [15:0] ok_cnt,
  output logic [15:0] drop_cnt
);

  // Handshake: axiov/axiod and frame_done are single-cycle strobes with no
  // back-pressure; the consumer must take them in the cycle they are high.

  typedef enum logic [2:0] {IDLE, ADDR, PASS, SKIP, DONE} state_t;

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic        bad_q, bad_d;
  logic [1:0]  dibit_q, dibit_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic        mac_hit_q, mac_hit_d;
  logic        bc_hit_q, bc_hit_d;
  logic        axiov_q, axiov_d;
  logic [7:0]  axiod_q, axiod_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic [10:0] frame_len_q, frame_len_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic [7:0]  byte_now;
  logic [10:0] byte_cnt_inc;
  logic [7:0]  mac_byte;
  logic        verdict_ok;

  assign byte_now     = {axiid, sr_q[7:2]};
  assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign verdict_ok   = (dibit_q == 2'd0) && (byte_cnt_q >= MIN_L) &&
                        (byte_cnt_q <= MAX_L) && !bad_q;

  always_comb begin
    case (byte_cnt_q[2:0])
      3'd0:    mac_byte = MAC_ADDR[47:40];
      3'd1:    mac_byte = MAC_ADDR[39:32];
      3'd2:    mac_byte = MAC_ADDR[31:24];
      3'd3:    mac_byte = MAC_ADDR[23:16];
      3'd4:    mac_byte = MAC_ADDR[15:8];
      default: mac_byte = MAC_ADDR[7:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q | ~axiiv;
    bad_d        = bad_q;
    dibit_d      = dibit_q;
    byte_cnt_d   = byte_cnt_q;
    sr_d         = sr_q;
    mac_hit_d    = mac_hit_q;
    bc_hit_d     = bc_hit_q;
    axiov_d      = 1'b0;
    axiod_d      = axiod_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    frame_len_d  = frame_len_q;
    ok_cnt_d     = ok_cnt_q;
    drop_cnt_d   = drop_cnt_q;

    // Byte assembly runs identically in every in-frame state.
    if (axiiv && (state_q == ADDR || state_q == PASS || state_q == SKIP)) begin
      sr_d    = byte_now;
      dibit_d = dibit_q + 2'd1;
      if (dibit_q == 2'd3) byte_cnt_d = byte_cnt_inc;
    end

    case (state_q)
      IDLE: begin
        if (axiiv) begin
          if (en && armed_q) begin
            state_d    = ADDR;
            sr_d       = byte_now;
            dibit_d    = 2'd1;
            byte_cnt_d = 11'd0;
            bad_d      = 1'b0;
            mac_hit_d  = 1'b1;
            bc_hit_d   = 1'b1;
          end else begin
            state_d = SKIP;
            bad_d   = 1'b0;
          end
        end
      end
      ADDR: begin
        if (!axiiv) begin
          state_d = IDLE;
        end else if (dibit_q == 2'd3) begin
          mac_hit_d = mac_hit_q && (byte_now == mac_byte);
          bc_hit_d  = bc_hit_q && (byte_now == 8'hFF);
          if (byte_cnt_q == 11'd5) begin
            state_d = (mac_hit_d || bc_hit_d) ? PASS : SKIP;
            bad_d   = 1'b0;
          end
        end
      end
      PASS: begin
        if (!axiiv) begin
          state_d = DONE;
        end else if (dibit_q == 2'd3) begin
          if (byte_cnt_inc > MAX_L) begin
            state_d = SKIP;
            bad_d   = 1'b1;
          end else begin
            axiov_d = 1'b1;
            axiod_d = byte_now;
          end
        end
      end
      SKIP: begin
        if (!axiiv) state_d = bad_q ? DONE : IDLE;
      end
      DONE: begin
        state_d = axiiv ? SKIP : IDLE;
        bad_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Verdict registers load on the edge into DONE so they are visible with frame_done.
    if (state_d == DONE && state_q != DONE) begin
      frame_done_d = 1'b1;
      frame_len_d  = byte_cnt_q;
      frame_ok_d   = verdict_ok;
      if (verdict_ok) begin
        if (ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
      end else begin
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      bad_q        <= 1'b0;
      dibit_q      <= 2'd0;
      byte_cnt_q   <= 11'd0;
      sr_q         <= 8'd0;
      mac_hit_q    <= 1'b0;
      bc_hit_q     <= 1'b0;
      axiov_q      <= 1'b0;
      axiod_q      <= 8'd0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_len_q  <= 11'd0;
      ok_cnt_q     <= 16'd0;
      drop_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      bad_q        <= bad_d;
      dibit_q      <= dibit_d;
      byte_cnt_q   <= byte_cnt_d;
      sr_q         <= sr_d;
      mac_hit_q    <= mac_hit_d;
      bc_hit_q     <= bc_hit_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      frame_len_q  <= frame_len_d;
      ok_cnt_q     <= ok_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign frame_len  = frame_len_q;
  assign ok_cnt     = ok_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
